// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Small FIFO of committed word stores sitting between the datapath and the
// data memory. Stores are pushed from the datapath and drained in order, one
// per cycle, whenever the memory grants a write slot. Loads can look up the
// buffer and take data forwarded from the youngest matching store.
//
// Parameters
//   DEPTH      number of buffered entries (power of two, >= 2)
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset (clears pointers and count)
//   st_valid   datapath presents a store this cycle
//   st_addr    store byte address (bits [1:0] stored but ignored for matching)
//   st_wd      store write data
//   st_pc      PC of the store instruction
//   st_ready   buffer not full, a store can be accepted this cycle
//   drain_en   data memory can take a write this cycle
//   dm_we      write enable to data memory (drain_en and not empty)
//   dm_addr    head entry address (0 when empty)
//   dm_wd      head entry data (0 when empty)
//   dm_pc      head entry PC (0 when empty)
//   ld_addr    load address for the forwarding lookup
//   fwd_hit    some occupied entry matches ld_addr at word granularity
//   fwd_data   data of the youngest matching entry (0 when no hit)
//   empty      buffer holds no entries
//   count      number of occupied entries
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_wd,
    input  logic [31:0]              st_pc,
    output logic                     st_ready,
    input  logic                     drain_en,
    output logic                     dm_we,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_wd,
    output logic [31:0]              dm_pc,
    input  logic [31:0]              ld_addr,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    // Entry storage; contents are don't-care outside the occupied window,
    // so it carries no reset.
    logic [31:0] addr_mem_r [DEPTH];
    logic [31:0] wd_mem_r   [DEPTH];
    logic [31:0] pc_mem_r   [DEPTH];

    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic          empty_s;
    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic          fwd_hit_s;
    logic [31:0]   fwd_data_s;

    // Byte offset of the load address does not take part in word matching.
    logic          unused_ld_off_s;
    assign unused_ld_off_s = ^ld_addr[1:0];

    // Status comes from registered occupancy only, so st_ready never depends
    // on drain_en: a full buffer refuses a push even while it drains.
    assign empty_s = (count_r == CNT_ZERO);
    assign ready_s = (count_r != CNT_FULL);
    assign push_s  = st_valid && ready_s;
    // An empty buffer cannot pop, so a store pushed this cycle is never
    // drained in the same cycle.
    assign pop_s   = drain_en && !empty_s;

    assign st_ready = ready_s;
    assign empty    = empty_s;
    assign count    = count_r;
    assign dm_we    = pop_s;
    assign dm_addr  = empty_s ? 32'h0000_0000 : addr_mem_r[head_r];
    assign dm_wd    = empty_s ? 32'h0000_0000 : wd_mem_r[head_r];
    assign dm_pc    = empty_s ? 32'h0000_0000 : pc_mem_r[head_r];
    assign fwd_hit  = fwd_hit_s;
    assign fwd_data = fwd_data_s;

    // Pointer and occupancy update; reset wins over any push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry write at the tail slot on an accepted push.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            addr_mem_r[tail_r] <= st_addr;
            wd_mem_r[tail_r]   <= st_wd;
            pc_mem_r[tail_r]   <= st_pc;
        end
    end

    // Forwarding lookup: walk occupied slots from oldest to youngest so the
    // last match seen is the youngest one. The head being popped this cycle
    // still counts as occupied; the store being pushed is not yet visible.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 32'h0000_0000;
        for (int i = 0; i < DEPTH; i++) begin
            logic          occ_m;
            logic          match_m;
            logic [AW-1:0] slot_m;
            slot_m     = head_r + AW'(i);
            occ_m      = (CW'(i) < count_r);
            match_m    = occ_m && (addr_mem_r[slot_m][31:2] == ld_addr[31:2]);
            fwd_hit_s  = fwd_hit_s | match_m;
            fwd_data_s = match_m ? wd_mem_r[slot_m] : fwd_data_s;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Directed scenarios followed by a randomized phase. A queue of entries
// models the buffer; every cycle all outputs are compared against values
// derived from that queue and the current inputs.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_wd;
    logic [31:0]   st_pc;
    logic          st_ready;
    logic          drain_en;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wd;
    logic [31:0]   dm_pc;
    logic [31:0]   ld_addr;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic          empty;
    logic [CW-1:0] count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] wlog[$];
    int          checks = 0;
    int          errors = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_wd    (st_wd),
        .st_pc    (st_pc),
        .st_ready (st_ready),
        .drain_en (drain_en),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wd    (dm_wd),
        .dm_pc    (dm_pc),
        .ld_addr  (ld_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .empty    (empty),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs (called just after a falling edge) and let them settle.
    task automatic drv(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic dr, input logic [31:0] ld);
        st_valid = v;
        st_addr  = a;
        st_wd    = d;
        st_pc    = a ^ 32'h5A5A_0000 ^ d;
        drain_en = dr;
        ld_addr  = ld;
        #1;
    endtask

    // Compare every output against the queue model, then clock and update it.
    task automatic step();
        int          n;
        logic        exp_hit;
        logic [31:0] exp_fd;
        logic        push_ok;
        logic        pop_ok;
        n       = mq.size();
        exp_hit = 1'b0;
        exp_fd  = 32'h0;
        foreach (mq[i]) begin
            if (mq[i].a[31:2] == ld_addr[31:2]) begin
                exp_hit = 1'b1;
                exp_fd  = mq[i].d;
            end
        end
        chk("count",    32'(count),    32'(n));
        chk("empty",    32'(empty),    32'(n == 0));
        chk("st_ready", 32'(st_ready), 32'(n < DEPTH));
        chk("dm_we",    32'(dm_we),    32'(drain_en && n > 0));
        chk("dm_addr",  dm_addr,       (n > 0) ? mq[0].a : 32'h0);
        chk("dm_wd",    dm_wd,         (n > 0) ? mq[0].d : 32'h0);
        chk("dm_pc",    dm_pc,         (n > 0) ? mq[0].p : 32'h0);
        chk("fwd_hit",  32'(fwd_hit),  32'(exp_hit));
        chk("fwd_data", fwd_data,      exp_fd);
        if (dm_we === 1'b1) wlog.push_back(dm_wd);
        push_ok = st_valid && (n < DEPTH);
        pop_ok  = drain_en && (n > 0);
        @(posedge clk);
        if (reset) begin
            mq.delete();
        end else begin
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back('{a: st_addr, d: st_wd, p: st_pc});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic dr);
        drv(1'b0, 32'h0, 32'h0, dr, 32'hFFFF_FFF0);
    endtask

    initial begin
        reset = 1'b1;
        drv(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();

        // Reset state
        idle(1'b1);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_empty", 32'(empty),    32'd1);
        chk("rst_dm_we", 32'(dm_we),    32'd0);
        step();

        // Single store drains one cycle after it is pushed
        drv(1'b1, 32'h10, 32'hAAAA_0001, 1'b1, 32'h0);
        chk("r31_no_same_cycle", 32'(dm_we), 32'd0);
        step();
        idle(1'b1);
        chk("r31_we",   32'(dm_we), 32'd1);
        chk("r31_addr", dm_addr,    32'h10);
        chk("r31_wd",   dm_wd,      32'hAAAA_0001);
        step();
        idle(1'b1);
        chk("r31_empty", 32'(empty), 32'd1);
        step();

        // Fill, overflow attempt, ordered drain
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 32'h0);
            step();
        end
        idle(1'b0);
        chk("r32_count", 32'(count),    32'd4);
        chk("r32_ready", 32'(st_ready), 32'd0);
        step();
        drv(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h40);
        step();
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("r32_order", dm_addr, 32'(i * 4));
            step();
        end

        // Forwarding picks the youngest match, word granularity
        drv(1'b1, 32'h20, 32'h11, 1'b0, 32'h0);  step();
        drv(1'b1, 32'h20, 32'h22, 1'b0, 32'h0);  step();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 32'h23);
        chk("r33_hit",  32'(fwd_hit), 32'd1);
        chk("r33_data", fwd_data,     32'h22);
        step();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 32'h24);
        chk("r33_miss",      32'(fwd_hit), 32'd0);
        chk("r33_miss_data", fwd_data,     32'h0);
        step();

        // Push+drain keeps count; full push+drain rejects the push
        drv(1'b1, 32'h30, 32'h33, 1'b1, 32'h20);
        step();
        idle(1'b0);
        chk("r34_count2", 32'(count), 32'd2);
        step();
        drv(1'b1, 32'h34, 32'h34, 1'b0, 32'h0);  step();
        drv(1'b1, 32'h38, 32'h38, 1'b0, 32'h0);  step();
        drv(1'b1, 32'h50, 32'h55, 1'b1, 32'h50);
        step();
        idle(1'b0);
        chk("r34_count3", 32'(count), 32'd3);
        step();
        repeat (3) begin
            idle(1'b1);
            step();
        end

        // Continuous push/drain across pointer wrap
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 32'h200 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b1, 32'h200);
            step();
        end
        repeat (3) begin
            idle(1'b1);
            step();
        end
        chk("r35_nwrites", 32'(wlog.size()), 32'd10);
        for (int i = 0; i < 10 && i < wlog.size(); i++) begin
            chk("r35_seq", wlog[i], 32'hC0DE_0000 + 32'(i));
        end

        // Reset with three entries and a simultaneous push
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'h300 + 32'(i * 4), 32'hE000_0000 + 32'(i), 1'b0, 32'h0);
            step();
        end
        reset = 1'b1;
        drv(1'b1, 32'h400, 32'h4444, 1'b0, 32'h300);
        step();
        reset = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 1'b1, 32'h300);
        chk("r36_count", 32'(count),   32'd0);
        chk("r36_empty", 32'(empty),   32'd1);
        chk("r36_we",    32'(dm_we),   32'd0);
        chk("r36_fwd",   32'(fwd_hit), 32'd0);
        step();

        // Randomized traffic with a small address pool to provoke hits
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            drv(($urandom_range(0, 99) < 60),
                32'h100 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
                $urandom,
                ($urandom_range(0, 99) < 45),
                32'h100 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3)));
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered store entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port st_valid  input  1  datapath presents a store this cycle.
REQ-005 SHALL have port st_addr  input  32  store byte address (word store; bits [1:0] kept, ignored for matching).
REQ-006 SHALL have port st_wd  input  32  store write data.
REQ-007 SHALL have port st_pc  input  32  PC of the store instruction.
REQ-008 SHALL have port st_ready  output  1  buffer can accept a store this cycle (not full).
REQ-009 SHALL have port drain_en  input  1  downstream data memory may take a write this cycle.
REQ-010 SHALL have port dm_we  output  1  write enable to data memory.
REQ-011 SHALL have ports dm_addr, dm_wd, dm_pc  output  32 each  address, data, PC of the head entry.
REQ-012 SHALL have port ld_addr  input  32  load address for forwarding lookup.
REQ-013 SHALL have port fwd_hit  output  1  a buffered store matches ld_addr.
REQ-014 SHALL have port fwd_data  output  32  data of the youngest matching entry; 0 when no hit.
REQ-015 SHALL have ports empty  output  1  and count  output  $clog2(DEPTH)+1  occupancy status.

Function
REQ-016 SHALL hold entries in FIFO order with head/tail pointers wrapping modulo DEPTH and a count register.
REQ-017 SHALL drive st_ready = (count != DEPTH), derived from registered state only.
REQ-018 SHALL accept (push) a store on a rising edge when st_valid && st_ready; st_valid while !st_ready SHALL be ignored with no state change.
REQ-019 SHALL drive dm_we = drain_en && !empty combinationally; dm_addr/dm_wd/dm_pc SHALL show the head entry whenever !empty and 0 when empty.
REQ-020 SHALL pop the head entry on a rising edge when dm_we is 1; exactly one entry drains per cycle.
REQ-021 SHALL, on simultaneous push and pop, update both pointers and leave count unchanged.
REQ-022 SHALL, when full, reject a push even if a pop occurs in the same cycle (st_ready computed before pop).
REQ-023 SHALL NOT drain a store in the cycle it is pushed; minimum push-to-dm_we latency is 1 cycle.
REQ-024 SHALL compare ld_addr[31:2] against st_addr[31:2] of every occupied entry combinationally; fwd_hit=1 if any match, fwd_data from the youngest (closest to tail) match.
REQ-025 SHALL exclude the store being pushed in the current cycle from forwarding.
REQ-026 SHALL treat the head entry being popped this cycle as still occupied for forwarding.
REQ-027 SHALL preserve FIFO order across pointer wrap-around with no lost or duplicated entry.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, clear head, tail, count to 0, discarding all buffered entries, overriding any simultaneous push or pop.
REQ-029 SHALL, after reset, present st_ready=1, empty=1, count=0, dm_we=0, dm_addr/dm_wd/dm_pc=0, fwd_hit=0, fwd_data=0.
REQ-030 SHALL not require entry data storage to be cleared by reset.

Verification
REQ-031 Push addr 0x10 data 0xAAAA0001 with drain_en=1 -> next cycle dm_we=1, dm_addr=0x10, dm_wd=0xAAAA0001; following cycle empty=1.
REQ-032 drain_en=0, push 4 stores 0x0,0x4,0x8,0xC -> count=4, st_ready=0; 5th st_valid ignored; drain_en=1 -> writes appear in order 0x0,0x4,0x8,0xC over 4 cycles.
REQ-033 drain_en=0, push 0x20<-0x11 then 0x20<-0x22, ld_addr=0x23 -> fwd_hit=1, fwd_data=0x22; ld_addr=0x24 -> fwd_hit=0, fwd_data=0.
REQ-034 count=2, push and drain same cycle -> count stays 2; full with push+drain -> push rejected, count=3.
REQ-035 Push/drain 10 stores continuously (pointer wrap) -> all 10 written in order, none duplicated.
REQ-036 Buffer holding 3 entries, reset=1 with st_valid=1 -> next cycle count=0, empty=1, dm_we=0, fwd_hit=0.
